// File: rtl/vdp_timing_pkg.sv
// Shared constants for the VGA raster and the VDP interrupt logic.
//   Raster geometry for 640x480@60 (800x525 totals), sync windows,
//   the SMS active window (192 lines, each doubled onto two VGA rows),
//   the frame-interrupt row, and VDP register indices/bits.
package vdp_timing_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;   // 800
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;   // 525

  localparam int ACT_TOP       = 48;
  localparam int ACT_LINES     = 192;
  localparam int FRAME_IRQ_ROW = 434;

  // Sized counter positions so comparisons stay at counter width.
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_ROWS   = 10'(V_VIS);
  localparam logic [9:0] HSYNC_START  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HSYNC_END    = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VSYNC_START  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VSYNC_END    = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] ACT_FIRST    = 10'(ACT_TOP);
  // Last VGA row that belongs to an SMS line index 0..ACT_LINES.
  localparam logic [9:0] ACT_LAST     = 10'(ACT_TOP + 2 * ACT_LINES + 1);
  localparam logic [9:0] FRAME_ROW    = 10'(FRAME_IRQ_ROW);
  localparam logic [8:0] SLINE_MAX    = 9'(ACT_LINES);

  localparam int REG_MODE1    = 0;
  localparam int REG_MODE2    = 1;
  localparam int REG_LINECNT  = 10;
  localparam int LINE_IE_BIT  = 4;
  localparam int FRAME_IE_BIT = 5;

  // SMS line index of a VGA row inside the active window.
  function automatic logic [8:0] smsLineIdx(input logic [9:0] vPos);
    return 9'((vPos - ACT_FIRST) >> 1);
  endfunction

endpackage

// File: rtl/vdp_line_irq.sv
// VDP line-interrupt counter, frame/line pending flags, status byte and
// the registered active-low Z80 interrupt.
//   clk, rst          : pixel clock, synchronous active-high reset
//   lineEvent         : one-cycle strobe at the start of every VGA row
//   smsLineStart      : row is the first VGA row of an SMS line 0..192
//   inWindow          : row lies inside the SMS active window
//   frameEvent        : row is the frame-interrupt row
//   lineReload        : line counter reload value (reg 10)
//   lineIe, frameIe   : interrupt enables
//   status_rd         : CPU control-port read strobe (clears both flags)
//   status            : {frame_flag, 7'd0}
//   line_flag         : pending line interrupt
//   INT_L             : active-low interrupt, one cycle behind the flags
module vdp_line_irq
  import vdp_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lineEvent,
  input  logic       smsLineStart,
  input  logic       inWindow,
  input  logic       frameEvent,
  input  logic [7:0] lineReload,
  input  logic       lineIe,
  input  logic       frameIe,
  input  logic       status_rd,
  output logic [7:0] status,
  output logic       line_flag,
  output logic       INT_L
);

  logic [7:0] lineCnt;
  logic       frameFlag;
  logic       lineSet;
  logic       frameSet;

  assign lineSet  = lineEvent && smsLineStart && (lineCnt == 8'd0);
  assign frameSet = lineEvent && frameEvent;
  assign status   = {frameFlag, 7'd0};

  always_ff @(posedge clk) begin
    if (rst) begin
      lineCnt   <= 8'hFF;
      line_flag <= 1'b0;
      frameFlag <= 1'b0;
      INT_L     <= 1'b1;
    end else begin
      // Odd rows of the window leave the counter alone; rows outside the
      // window keep it primed with the reload value.
      if (lineEvent) begin
        if (smsLineStart)
          lineCnt <= (lineCnt == 8'd0) ? lineReload : lineCnt - 8'd1;
        else if (!inWindow)
          lineCnt <= lineReload;
      end

      // A set in the same cycle as a status read wins.
      if (lineSet)
        line_flag <= 1'b1;
      else if (status_rd)
        line_flag <= 1'b0;

      if (frameSet)
        frameFlag <= 1'b1;
      else if (status_rd)
        frameFlag <= 1'b0;

      INT_L <= ~((frameFlag & frameIe) | (line_flag & lineIe));
    end
  end

endmodule

// File: rtl/vdp_vga_timing.sv
// 640x480@60 raster timing for the Mode 4 display path.
//   clk, rst     : 25 MHz pixel clock, synchronous active-high reset
//   regFile      : VDP registers (reg0[4] line IE, reg1[5] frame IE,
//                  reg10 line counter reload)
//   status_rd    : CPU control-port read strobe
//   col, row     : raster position (row forced to 0 in vertical blank)
//   hsync_L      : active-low hsync, registered (one cycle behind col)
//   vsync_L      : active-low vsync, registered
//   vblank       : vertical counter beyond the visible rows
//   frame_start  : one-cycle pulse while the raster sits at (0,0)
//   status       : VDP status byte {frame_flag, 7'd0}
//   line_flag    : pending line interrupt
//   INT_L        : active-low Z80 interrupt
module vdp_vga_timing
  import vdp_timing_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0][7:0] regFile,
  input  logic            status_rd,
  output logic [9:0]      col,
  output logic [8:0]      row,
  output logic            hsync_L,
  output logic            vsync_L,
  output logic            vblank,
  output logic            frame_start,
  output logic [7:0]      status,
  output logic            line_flag,
  output logic            INT_L
);

  logic [9:0] hCnt;
  logic [9:0] vCnt;
  logic       hWrap;
  logic       vWrap;
  logic       lineEvent;
  logic       inWindow;
  logic       smsLineStart;
  logic [9:0] actOffset;
  logic       unusedRegBits;

  assign hWrap = (hCnt == H_LAST);
  assign vWrap = (vCnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hCnt        <= '0;
      vCnt        <= '0;
      hsync_L     <= 1'b1;
      vsync_L     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hCnt <= hWrap ? 10'd0 : hCnt + 10'd1;
      if (hWrap)
        vCnt <= vWrap ? 10'd0 : vCnt + 10'd1;
      hsync_L <= !((hCnt >= HSYNC_START) && (hCnt <= HSYNC_END));
      vsync_L <= !((vCnt >= VSYNC_START) && (vCnt <= VSYNC_END));
      // Registered from the wrap so the pulse lines up with (0,0).
      frame_start <= hWrap && vWrap;
    end
  end

  assign col    = hCnt;
  assign vblank = !(vCnt < V_VIS_ROWS);
  assign row    = vblank ? 9'd0 : vCnt[8:0];

  assign lineEvent    = (hCnt == 10'd0);
  assign inWindow     = (vCnt >= ACT_FIRST) && (vCnt <= ACT_LAST);
  assign actOffset    = vCnt - ACT_FIRST;
  assign smsLineStart = inWindow && !actOffset[0] &&
                        (smsLineIdx(vCnt) <= SLINE_MAX);

  assign unusedRegBits = ^{regFile[9:2], regFile[REG_MODE1][7:5],
                           regFile[REG_MODE1][3:0], regFile[REG_MODE2][7:6],
                           regFile[REG_MODE2][4:0]};

  vdp_line_irq uLineIrq (
    .clk          (clk),
    .rst          (rst),
    .lineEvent    (lineEvent),
    .smsLineStart (smsLineStart),
    .inWindow     (inWindow),
    .frameEvent   (vCnt == FRAME_ROW),
    .lineReload   (regFile[REG_LINECNT]),
    .lineIe       (regFile[REG_MODE1][LINE_IE_BIT]),
    .frameIe      (regFile[REG_MODE2][FRAME_IE_BIT]),
    .status_rd    (status_rd),
    .status       (status),
    .line_flag    (line_flag),
    .INT_L        (INT_L)
  );

endmodule

// File: tb/tb_vdp_vga_timing.sv
module tb_vdp_vga_timing;

  logic             clk = 1'b0;
  logic             rst;
  logic [10:0][7:0] regFile;
  logic             statusRd;
  logic [9:0]       col;
  logic [8:0]       row;
  logic             hsyncL, vsyncL, vblank, frameStart, lineFlag, intL;
  logic [7:0]       status;

  int nChecks = 0;
  int nPass   = 0;

  // Reference raster position, independent of the DUT.
  int mH = 0;
  int mV = 0;

  always #20 clk = ~clk;

  vdp_vga_timing dut (
    .clk         (clk),
    .rst         (rst),
    .regFile     (regFile),
    .status_rd   (statusRd),
    .col         (col),
    .row         (row),
    .hsync_L     (hsyncL),
    .vsync_L     (vsyncL),
    .vblank      (vblank),
    .frame_start (frameStart),
    .status      (status),
    .line_flag   (lineFlag),
    .INT_L       (intL)
  );

  always @(posedge clk) begin
    if (rst) begin
      mH <= 0;
      mV <= 0;
    end else if (mH == 799) begin
      mH <= 0;
      mV <= (mV == 524) ? 0 : mV + 1;
    end else begin
      mH <= mH + 1;
    end
  end

  typedef struct {
    int   v;
    int   h;
    int   row;
    logic vb;
    logic hs;
    logic vs;
  } posVec_t;

  posVec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d (vcnt %0d col %0d)",
                  name, act, exp, mV, mH);
  endtask

  task automatic waitPos(input int v, input int h);
    int n = 0;
    while (!(mV == v && mH == h)) begin
      @(negedge clk);
      n++;
      if (n > 420010) begin
        nChecks++;
        $display("FAIL waitPos: position (%0d,%0d) not reached, got (%0d,%0d)",
                 v, h, mV, mH);
        break;
      end
    end
  endtask

  // Strobe status_rd for one cycle; returns at the negedge after the strobe.
  task automatic pulseRead();
    statusRd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    statusRd = 1'b0;
  endtask

  initial begin
    int colErr = 0, rowErr = 0, vbErr = 0;
    int hsRun = 0, hsRuns = 0, hsBadLen = 0, hsBadStart = 0;
    int vsRun = 0, vsRuns = 0, vsLen = 0, vsStartV = -1, vsStartH = -1;
    int fsCount = 0, fsV = -1, fsH = -1;
    logic hsPrev, vsPrev;
    int lineRows[3];

    tbl[0]  = '{440, 656, 440, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{440, 657, 440, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{440, 752, 440, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{440, 753, 440, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{479,   0, 479, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{480,   5,   0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{490,   0,   0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{490,   1,   0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{492,   0,   0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{492,   1,   0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{524, 799,   0, 1'b1, 1'b1, 1'b1};
    lineRows = '{54, 62, 70};

    rst      = 1'b1;
    regFile  = '0;
    statusRd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", col, 0);
    check("rst_row", row, 0);
    check("rst_hsync", hsyncL, 1);
    check("rst_vsync", vsyncL, 1);
    check("rst_status", status, 0);
    check("rst_line_flag", lineFlag, 0);
    check("rst_int", intL, 1);
    check("rst_frame_start", frameStart, 0);
    rst = 1'b0;

    // One full frame of raster checks.
    hsPrev = hsyncL;
    vsPrev = vsyncL;
    for (int i = 0; i < 420000; i++) begin
      @(negedge clk);
      if (col != 10'(mH)) colErr++;
      if (row != ((mV < 480) ? 9'(mV) : 9'd0)) rowErr++;
      if (vblank != (mV >= 480)) vbErr++;
      if (frameStart) begin
        fsCount++;
        fsV = mV;
        fsH = mH;
      end
      if (!hsyncL) begin
        if (hsPrev && mH != 657) hsBadStart++;
        hsRun++;
      end else if (hsRun != 0) begin
        if (hsRun != 96) hsBadLen++;
        hsRuns++;
        hsRun = 0;
      end
      if (!vsyncL) begin
        if (vsPrev) begin
          vsStartV = mV;
          vsStartH = mH;
        end
        vsRun++;
      end else if (vsRun != 0) begin
        vsLen = vsRun;
        vsRuns++;
        vsRun = 0;
      end
      hsPrev = hsyncL;
      vsPrev = vsyncL;
    end
    check("sweep_col", colErr, 0);
    check("sweep_row", rowErr, 0);
    check("sweep_vblank", vbErr, 0);
    check("frame_start_count", fsCount, 1);
    check("frame_start_pos", fsV * 1000 + fsH, 0);
    check("hsync_runs", hsRuns, 525);
    check("hsync_len", hsBadLen, 0);
    check("hsync_start", hsBadStart, 0);
    check("vsync_runs", vsRuns, 1);
    check("vsync_len", vsLen, 1600);
    check("vsync_start", vsStartV * 1000 + vsStartH, 490001);

    // Frame 2: line interrupt with reg10 = 3, then frame interrupt.
    regFile[10] = 8'd3;
    regFile[0]  = 8'h10;
    regFile[1]  = 8'h20;
    pulseRead();
    for (int k = 0; k < 3; k++) begin
      waitPos(lineRows[k], 0);
      check("line_flag_before", lineFlag, 0);
      waitPos(lineRows[k], 1);
      check("line_flag_rise", lineFlag, 1);
      waitPos(lineRows[k], 2);
      check("line_int_low", intL, 0);
      pulseRead();
      check("line_flag_clr", lineFlag, 0);
      @(negedge clk);
      check("line_int_high", intL, 1);
    end
    regFile[0] = 8'h00;

    waitPos(433, 0);
    pulseRead();
    waitPos(434, 0);
    check("frame_status_pre", status, 0);
    waitPos(434, 1);
    check("frame_status_set", status, 8'h80);
    waitPos(434, 2);
    check("frame_int_low", intL, 0);
    waitPos(434, 10);
    check("frame_status_strobe", status, 8'h80);
    pulseRead();
    check("frame_status_clr", status, 0);
    @(negedge clk);
    check("frame_int_high", intL, 1);

    for (int i = 0; i < 11; i++) begin
      waitPos(tbl[i].v, tbl[i].h);
      check("tbl_col", col, tbl[i].h);
      check("tbl_row", row, tbl[i].row);
      check("tbl_vblank", vblank, tbl[i].vb);
      check("tbl_hsync", hsyncL, tbl[i].hs);
      check("tbl_vsync", vsyncL, tbl[i].vs);
    end

    // Frame 3: reg10 = 0 flags every SMS line; simultaneous set/read.
    regFile[10] = 8'd0;
    waitPos(46, 0);
    pulseRead();
    waitPos(47, 1);
    check("r0_pre_window", lineFlag, 0);
    waitPos(48, 1);
    check("r0_sline0", lineFlag, 1);
    pulseRead();
    waitPos(49, 1);
    check("r0_odd_row", lineFlag, 0);
    waitPos(50, 1);
    check("r0_sline1", lineFlag, 1);
    pulseRead();
    waitPos(432, 1);
    check("r0_sline192", lineFlag, 1);
    pulseRead();
    waitPos(433, 1);
    check("r0_last_odd", lineFlag, 0);
    waitPos(434, 0);
    check("sim_status_pre", status, 0);
    pulseRead();
    check("sim_status_set", status, 8'h80);
    check("sim_line_clr", lineFlag, 0);
    waitPos(434, 3);
    check("sim_status_hold", status, 8'h80);
    check("sim_int_low", intL, 0);
    regFile[1] = 8'h00;
    @(negedge clk);
    check("mask_int_high", intL, 1);
    check("mask_status_kept", status, 8'h80);
    regFile[1] = 8'h20;
    @(negedge clk);
    check("unmask_int_low", intL, 0);

    // Frame 4: reset mid-frame.
    regFile[10] = 8'd3;
    regFile[0]  = 8'h10;
    waitPos(200, 300);
    check("prerst_status", status, 8'h80);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_col", col, 0);
    check("midrst_row", row, 0);
    check("midrst_status", status, 0);
    check("midrst_line_flag", lineFlag, 0);
    check("midrst_int", intL, 1);
    rst = 1'b0;
    waitPos(52, 1);
    check("postrst_line_pre", lineFlag, 0);
    waitPos(54, 1);
    check("postrst_line_rise", lineFlag, 1);
    waitPos(54, 2);
    check("postrst_int_low", intL, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/vdp_vga_timing.md
Name: vdp_vga_timing

Overview:
- Upstream timing stage for the Mode 4 display interface. It generates 640x480@60 VGA raster counters (col, row) and the hsync/vsync pulses from the 25 MHz pixel clock.
- It derives the SMS 192-line active window, with each SMS line doubled onto 2 VGA rows.
- It runs the VDP line-interrupt down-counter (reg 10) and the frame-interrupt flag, and drives the status byte and the Z80 INT_L line.

Parameters:
- H_VIS, 640, visible pixels per row
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible rows
- V_FP, 10, vertical front porch (rows)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- ACT_TOP, 48, first VGA row of the SMS active area
- ACT_LINES, 192, SMS active lines (each = 2 VGA rows)

Ports:
- clk, in, 1, 25 MHz pixel clock
- rst, in, 1, synchronous active-high reset
- regFile, in, [10:0][7:0], VDP registers; uses reg0[4] (line IE), reg1[5] (frame IE), reg10 (line reload)
- status_rd, in, 1, one-cycle strobe: CPU read of control port
- col, out, 10, horizontal counter 0..799
- row, out, 9, visible row 0..479; forced 0 when vertical counter >= V_VIS
- hsync_L, out, 1, active-low hsync
- vsync_L, out, 1, active-low vsync
- vblank, out, 1, high when vertical counter >= V_VIS
- frame_start, out, 1, one-cycle pulse at col 0, vcnt 0
- status, out, 8, {frame_flag, 7'd0}
- line_flag, out, 1, pending line interrupt
- INT_L, out, 1, active-low interrupt to Z80

Behaviour:
- One clock domain. Reset is synchronous and active-high (clk, rst).
- Reset values:
  - hcnt = 0, vcnt = 0
  - hsync_L = 1, vsync_L = 1
  - frame/line flags = 0, line counter = 8'hFF
  - INT_L = 1, frame_start = 0
- Reset mid-frame restarts the raster at (0,0) on the next cycle.
- Horizontal counter: hcnt increments every clk and wraps 799 -> 0.
- Vertical counter: vcnt increments when hcnt == 799 and wraps 524 -> 0.
- col = hcnt, combinational from the registers, 0-cycle latency.
- row = vcnt[8:0] if vcnt < 480, else 0.
- hsync_L = 0 for hcnt in [656,751].
- vsync_L = 0 for vcnt in [490,491].
- hsync_L and vsync_L are registered, so they lag col by 1 cycle; the display pipeline absorbs this.
- All event logic below is evaluated only at hcnt == 0 (line event).
- SMS line index:
  - Defined only for vcnt in [48,433]: sline = (vcnt-48)>>1.
  - An SMS line starts at an even offset (vcnt-48)[0] == 0.
- Line counter (8-bit), applied at an SMS line start with sline <= 192:
  - If count == 0: count <= reg10 and line_flag <= 1.
  - Else: count <= count - 1.
- Line counter at every line event with vcnt outside [48,433]: count <= reg10 (reload, no flag).
- Odd VGA rows of the active area leave the counter unchanged.
- reg10 = 0 raises the flag on every SMS line 0..192.
- Frame flag: set at the line event of vcnt == 434 (SMS line 193).
- Status read:
  - status_rd clears frame_flag and line_flag on the next edge.
  - status shows the pre-clear value during the strobe cycle.
- Simultaneous set and status_rd in the same cycle: the set wins and the flag stays 1.
- Interrupt: INT_L is registered, 1-cycle latency, and equals ~((frame_flag & reg1[5]) | (line_flag & reg0[4])).
- Changing an IE bit masks or unmasks INT_L without altering the flags.
- frame_start is registered and asserted for exactly one cycle per frame.

Decomposition:
- Package vdp_timing_pkg holds:
  - localparams H_TOTAL = 800, V_TOTAL = 525
  - sync start/end positions, ACT_TOP, ACT_LINES, FRAME_IRQ_ROW = 434
  - register index constants REG_MODE1 = 0, REG_MODE2 = 1, REG_LINECNT = 10
- One natural sub-module, vdp_line_irq, containing the line counter, the flags, status and INT_L. Its inputs are the line-event strobe, the SMS-line-start and in-window qualifiers, reg10 and status_rd.
- The raster counters and sync generation remain in the top module.

Test Plan:
- Reset, then run 420000 clocks -> col wraps at 799; vcnt wraps at 524; exactly one frame_start per 420000 clocks; hsync_L low for 96 clocks starting at col 656; vsync_L low for 1600 clocks starting at vcnt 490.
- row check -> row == 0 whenever vcnt >= 480; vblank == 1 over the same range.
- reg10 = 3, reg0[4] = 1 -> line_flag rises at the line event of SMS lines 3, 7, 11 (vcnt 54, 62, 70), provided status_rd clears it between events; INT_L goes low 1 cycle after each rise.
- reg1[5] = 1, reg0[4] = 0 -> status[7] = 1 and INT_L = 0 from vcnt 434; a status_rd pulse reads 8'h80, then status = 0 and INT_L = 1 two cycles later.
- status_rd asserted on the exact cycle frame_flag sets -> frame_flag remains 1 and status = 8'h80 afterwards.
- Assert rst at vcnt 200, col 300 -> the next cycle gives col = 0, row = 0, flags = 0, INT_L = 1, and the line counter reloads from reg10 at the first out-of-window line event.
